data_wbuf: RTL and testbench
============================

# data_wbuf

Write buffer with load forwarding. It sits between the core's data-memory port (`data_ce_o`/`data_we_o`/`data_addr_o`/`data_o`/`data_i`) and a data memory with a variable-latency req/ack handshake. Stores retire in one cycle into a small FIFO that drains in the background. Loads are forwarded from the buffer when possible; otherwise the core is stalled until memory returns data.

## Interface
- `DEPTH`, 4, number of buffered stores (power of two, ≥2)
- `AW`, 32, address width; `DW`, 32, data width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `core_ce_i`  in  1  core data request valid
- `core_we_i`  in  1  1 = store, 0 = load
- `core_addr_i`  in  AW  byte address; bits [1:0] ignored (word access only)
- `core_wdata_i`  in  DW  store data
- `core_rdata_o`  out  DW  load data, valid when `core_ce_i & ~core_we_i & ~stall_o`
- `stall_o`  out  1  core must hold its request and PC while high
- `wbuf_empty_o`  out  1  buffer empty and no memory access in flight (fence support)
- `mem_req_o`  out  1  memory request, held until acknowledged
- `mem_we_o`  out  1  memory write
- `mem_addr_o`  out  AW  memory word address, with [1:0] = 0
- `mem_wdata_o`  out  DW  memory write data
- `mem_ack_i`  in  1  transfer completes on the edge where `mem_req_o & mem_ack_i`
- `mem_rdata_i`  in  DW  read data, valid with `mem_ack_i` on reads

## Operation
- **FIFO.** `DEPTH` entries of {addr[AW-1:2], data}, with head/tail pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo `DEPTH`.
- **Store, not full.** Enqueue at the edge; `stall_o` = 0. Stores to the same address are appended, never merged.
- **Store, full.** `stall_o` = 1. Enqueue on the first edge where count < DEPTH. Full is the registered count, so a store never enqueues on the same edge a full buffer pops.
- **Load hit.** Address matches one or more valid entries. `core_rdata_o` = data of the youngest matching entry, combinationally; `stall_o` = 0.
- **Load miss.**
  - `stall_o` = 1 combinationally.
  - The read takes priority over queued writes but waits for any in-flight write to complete.
  - After `mem_ack_i`, read data is captured in `rdata_q`.
- **FSM states: IDLE, WRITE, READ, RDONE.**
  - IDLE → READ when a load miss is present.
  - IDLE → WRITE when count > 0 and there is no load miss.
  - WRITE, on ack: pop the head. Then go to READ if a load miss is present; stay in WRITE with the next head if count > 1; otherwise go to IDLE.
  - READ, on ack: go to RDONE.
  - RDONE (one cycle): `core_rdata_o` = `rdata_q`, `stall_o` = 0, then go to IDLE.
- **Memory outputs.** `mem_*` outputs are registered and change only on the edge entering or leaving WRITE/READ, or on a pop. `mem_req_o` stays high with stable address/data until ack.
- **Simultaneous enqueue and pop.** A store enqueue and a WRITE pop on the same edge both occur; count is unchanged.
- **`wbuf_empty_o`** = (count == 0) & (state == IDLE).
- **Reset (also mid-transfer).**
  - FIFO is flushed and pending stores are discarded.
  - state = IDLE.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `rdata_q` = 0.
  - `core_rdata_o` = 0 unless it is forwarding.
  - `wbuf_empty_o` = 1.
  - `stall_o` is combinational: 0 with no request.

## Timing
- Store, not full: 0 stall cycles.
- Load hit: 0 stall cycles.
- Load miss from IDLE, load presented in cycle 0:
  - `mem_req_o` rises in cycle 1.
  - An ack in cycle N (N ≥ 1) gives RDONE in cycle N+1, when `stall_o` drops and data is valid.
  - Minimum stall is 2 cycles.
- Load miss during WRITE: add the remaining write latency, plus one cycle for the READ launch after the write ack.
- Drain throughput with `mem_ack_i` tied high: one store per cycle after the first (IDLE→WRITE costs one cycle).
- `mem_ack_i` while `mem_req_o` = 0 is ignored.

## Structure
- Shared package `riscv_pkg`: FSM state enum (IDLE/WRITE/READ/RDONE), `WORD_BYTES`, and the address-to-word-index helper constant.
- One sub-module, `wbuf_entries`: storage array, pointers, count, full/empty, and the youngest-match forward search. It exposes head entry, enqueue, and pop.
- The top level holds the FSM, memory-port registers and `rdata_q`.

## Test plan
- **Store/drain.** Reset, then store 0x10 → 0xAAAA_0001, `mem_ack_i` tied 1. `stall_o` stays 0; one write with addr 0x10, data 0xAAAA_0001 appears; `wbuf_empty_o` returns to 1 two cycles later.
- **Forwarding.** Hold ack 0. Store 0x20 → 0x1, store 0x20 → 0x2, then load 0x22. `core_rdata_o` = 0x2 (youngest match) with no stall.
- **Full.** Hold ack 0 and issue 5 stores. The 5th sees `stall_o` = 1 until the first ack. FIFO wrap is then checked by 8 further stores drained in order.
- **Load miss behind write.** One store in flight, then load 0x40 misses. The write completes first, then a read with `mem_we_o` = 0, addr 0x40. Memory returns 0xDEAD_BEEF with ack delayed 3 cycles; `core_rdata_o` = 0xDEAD_BEEF in RDONE; remaining stores drain afterwards.
- **Reset mid-transfer.** Assert `rst` low during WRITE with 3 entries queued. `mem_req_o` drops immediately; after release no writes are issued and `wbuf_empty_o` = 1.
- **Stray ack.** `mem_ack_i` = 1 while idle. No state change and no pop.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-side write buffer: FSM states and word addressing.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RDONE = 2'd3
    } wbuf_state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);

endpackage

// File: rtl/wbuf_entries.sv
// Store FIFO of {word address, data} with head/next exposure and a youngest-match
// forwarding search over the valid entries.
module wbuf_entries
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic [AW-1:WORD_LSB]     enq_addr,
    input  logic [DW-1:0]            enq_data,
    input  logic                     pop,
    output logic [AW-1:WORD_LSB]     head_addr,
    output logic [DW-1:0]            head_data,
    output logic [AW-1:WORD_LSB]     next_addr,
    output logic [DW-1:0]            next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic [AW-1:WORD_LSB]     lookup_addr,
    output logic                     hit,
    output logic [DW-1:0]            hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:WORD_LSB] addr_q [DEPTH];
    logic [DW-1:0]        data_q [DEPTH];
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [PW-1:0]        head_nx;
    logic [PW-1:0]        idx;

    assign head_nx   = head_q + 1'b1;
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign next_addr = addr_q[head_nx];
    assign next_data = data_q[head_nx];
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

    // Storage is not reset: an entry only becomes visible through count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= enq_addr;
            data_q[tail_q] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (enq)
                tail_q <= tail_q + 1'b1;
            if (pop)
                head_q <= head_nx;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((k < int'(count)) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/data_wbuf.sv
// Data-side write buffer: one-cycle store retirement, background drain to a req/ack
// memory, load forwarding from buffered stores and stall-on-miss reads.
module data_wbuf
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_ce_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic [DW-1:0] core_rdata_o,
    output logic          stall_o,
    output logic          wbuf_empty_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE_CNT = (PW+1)'(1);

    wbuf_state_e          state_q;
    logic [DW-1:0]        rdata_q;
    logic [PW:0]          count;
    logic                 full;
    logic                 empty;
    logic                 hit;
    logic [DW-1:0]        hit_data;
    logic [AW-1:WORD_LSB] head_addr;
    logic [DW-1:0]        head_data;
    logic [AW-1:WORD_LSB] next_addr;
    logic [DW-1:0]        next_data;
    logic                 is_load;
    logic                 is_store;
    logic                 load_miss;
    logic                 xfer_done;
    logic                 enq;
    logic                 pop;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^core_addr_i[WORD_LSB-1:0];

    assign is_load   = core_ce_i & ~core_we_i;
    assign is_store  = core_ce_i & core_we_i;
    assign load_miss = is_load & ~hit;
    assign xfer_done = mem_req_o & mem_ack_i;
    assign enq       = is_store & ~full;
    assign pop       = (state_q == WRITE) & xfer_done;

    // RDONE releases the stalled load with the captured memory data.
    assign stall_o      = (is_store & full) | (load_miss & (state_q != RDONE));
    assign core_rdata_o = (state_q == RDONE) ? rdata_q : ((is_load & hit) ? hit_data : '0);
    assign wbuf_empty_o = empty & (state_q == IDLE);

    wbuf_entries #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_entries (
        .clk         (clk),
        .rst         (rst),
        .enq         (enq),
        .enq_addr    (core_addr_i[AW-1:WORD_LSB]),
        .enq_data    (core_wdata_i),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .lookup_addr (core_addr_i[AW-1:WORD_LSB]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_miss) begin
                        state_q    <= READ;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {core_addr_i[AW-1:WORD_LSB], {WORD_LSB{1'b0}}};
                    end else if (!empty) begin
                        state_q     <= WRITE;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {head_addr, {WORD_LSB{1'b0}}};
                        mem_wdata_o <= head_data;
                    end
                end
                WRITE: begin
                    // A waiting load miss overtakes the remaining queued stores.
                    if (xfer_done) begin
                        if (load_miss) begin
                            state_q    <= READ;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {core_addr_i[AW-1:WORD_LSB], {WORD_LSB{1'b0}}};
                        end else if (count > ONE_CNT) begin
                            mem_addr_o  <= {next_addr, {WORD_LSB{1'b0}}};
                            mem_wdata_o <= next_data;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_o <= 1'b0;
                            mem_we_o  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (xfer_done) begin
                        state_q   <= RDONE;
                        mem_req_o <= 1'b0;
                        rdata_q   <= mem_rdata_i;
                    end
                end
                RDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_wbuf.sv
// Bench for data_wbuf: directed scenarios plus random traffic against a program-order
// memory model (last store wins) and an in-order store queue for the drain side.
module tb_data_wbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_ce_i = 1'b0;
    logic          core_we_i = 1'b0;
    logic [AW-1:0] core_addr_i = '0;
    logic [DW-1:0] core_wdata_i = '0;
    logic [DW-1:0] core_rdata_o;
    logic          stall_o;
    logic          wbuf_empty_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    data_wbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ce_i    (core_ce_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_rdata_o (core_rdata_o),
        .stall_o      (stall_o),
        .wbuf_empty_o (wbuf_empty_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t         wq[$];
    logic [31:0] arch [logic [31:0]];
    logic [31:0] memv [logic [31:0]];

    int          n_pass = 0;
    int          n_total = 0;
    int          ack_mode = 0;
    int          req_age = 0;
    int          stall_run = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          wr_at_read = 0;
    int          base = 0;
    logic        accepted = 1'b0;
    logic        last_stall = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rd_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return memv.exists(word(a)) ? memv[word(a)] : dflt(word(a));
    endfunction

    function automatic logic [31:0] arch_val(input logic [31:0] a);
        return arch.exists(word(a)) ? arch[word(a)] : dflt(word(a));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Checks every cycle against the model and applies the events of the coming edge.
    task automatic evaluate();
        bit found;
        found      = 1'b0;
        last_stall = stall_o;
        last_rdata = core_rdata_o;
        if (wq.size() != 0 || mem_req_o) chk("empty_flag", wbuf_empty_o, 0);
        if (core_ce_i && core_we_i) chk("store_stall", stall_o, (wq.size() == DEPTH));
        if (core_ce_i && !core_we_i) begin
            foreach (wq[i]) if (wq[i].addr == word(core_addr_i)) found = 1'b1;
            if (found) chk("hit_stall", stall_o, 0);
            if (!stall_o) chk("load_data", core_rdata_o, arch_val(core_addr_i));
        end
        if (core_ce_i && stall_o) stall_run++;
        else stall_run = 0;
        if (stall_run > 60) begin
            chk("stall_bound", stall_run, 60);
            stall_run = 0;
        end
        if (mem_req_o && mem_ack_i) begin
            if (mem_we_o) begin
                chk("write_has_entry", (wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    chk("wr_addr", mem_addr_o, wq[0].addr);
                    chk("wr_data", mem_wdata_o, wq[0].data);
                    void'(wq.pop_front());
                end
                memv[word(mem_addr_o)] = mem_wdata_o;
                wr_count++;
                last_wr_addr = mem_addr_o;
                last_wr_data = mem_wdata_o;
            end else begin
                chk("rd_addr", mem_addr_o,
                    (core_ce_i && !core_we_i) ? word(core_addr_i) : 32'hFFFF_FFFF);
                rd_count++;
                last_rd_addr = mem_addr_o;
                wr_at_read   = wr_count;
            end
            req_age = 0;
        end
        if (core_ce_i && !stall_o) begin
            accepted = 1'b1;
            if (core_we_i) begin
                wq.push_back('{addr: word(core_addr_i), data: core_wdata_i});
                arch[word(core_addr_i)] = core_wdata_i;
            end
        end
    endtask

    // Entered and left at a falling edge.
    task automatic tick();
        if (mem_req_o) req_age++;
        else req_age = 0;
        case (ack_mode)
            0:       mem_ack_i = 1'b0;
            1:       mem_ack_i = 1'b1;
            2:       mem_ack_i = ($urandom_range(0, 2) == 0);
            default: mem_ack_i = (req_age >= 4);
        endcase
        mem_rdata_i = (mem_req_o && !mem_we_o) ? mem_val(mem_addr_o) : 32'h0BAD_0BAD;
        #1;
        evaluate();
        @(posedge clk);
        @(negedge clk);
        if (accepted) begin
            core_ce_i = 1'b0;
            accepted  = 1'b0;
        end
    endtask

    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] data);
        core_ce_i    = 1'b1;
        core_we_i    = we;
        core_addr_i  = addr;
        core_wdata_i = data;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
        present(we, addr, data);
        for (int i = 0; i < 80 && core_ce_i; i++) tick();
        chk("accept_in_time", core_ce_i, 0);
        core_ce_i = 1'b0;
    endtask

    task automatic drain();
        ack_mode = 1;
        for (int i = 0; i < 200 && (core_ce_i || wq.size() != 0 || !wbuf_empty_o); i++) tick();
        chk("drain_queue", wq.size(), 0);
        chk("drain_empty", wbuf_empty_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_empty", wbuf_empty_o, 1);
        chk("rst_stall", stall_o, 0);
        chk("rst_rdata", core_rdata_o, 0);
        rst = 1'b1;
        @(negedge clk);

        // Store then drain with ack tied high.
        ack_mode = 1;
        base = wr_count;
        issue(1'b1, 32'h10, 32'hAAAA_0001);
        chk("t1_stall", last_stall, 0);
        tick();
        chk("t1_busy", wbuf_empty_o, 0);
        tick();
        chk("t1_empty", wbuf_empty_o, 1);
        chk("t1_wr_count", wr_count - base, 1);
        chk("t1_wr_addr", last_wr_addr, 32'h10);
        chk("t1_wr_data", last_wr_data, 32'hAAAA_0001);

        // Forwarding of the youngest matching store.
        ack_mode = 0;
        issue(1'b1, 32'h20, 32'h1);
        issue(1'b1, 32'h20, 32'h2);
        present(1'b0, 32'h22, 32'h0);
        tick();
        chk("fwd_data", last_rdata, 32'h2);
        chk("fwd_stall", last_stall, 0);
        drain();

        // Full buffer, then wrap-around drain order.
        ack_mode = 0;
        base = wr_count;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'h80 + 4 * i, 32'hF000_0000 + i);
        present(1'b1, 32'h90, 32'hF000_0004);
        tick();
        chk("full_stall", last_stall, 1);
        tick();
        chk("full_stall_hold", last_stall, 1);
        ack_mode = 1;
        for (int i = 0; i < 20 && core_ce_i; i++) tick();
        chk("full_accepted", core_ce_i, 0);
        ack_mode = 2;
        for (int i = 0; i < 8; i++) issue(1'b1, 32'hA0 + 4 * (i % 3), 32'hE000_0000 + i);
        drain();
        chk("full_wr_total", wr_count - base, 13);

        // Load miss behind an in-flight write, delayed acks.
        memv[32'h40] = 32'hDEAD_BEEF;
        arch[32'h40] = 32'hDEAD_BEEF;
        ack_mode = 3;
        base = wr_count;
        issue(1'b1, 32'h30, 32'h11);
        issue(1'b1, 32'h34, 32'h22);
        present(1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 40 && core_ce_i; i++) tick();
        chk("miss_accepted", core_ce_i, 0);
        chk("miss_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("miss_rd_addr", last_rd_addr, 32'h40);
        chk("miss_write_first", wr_at_read - base, 1);
        drain();
        chk("miss_wr_total", wr_count - base, 2);

        // Reset while a write is outstanding with three stores queued.
        ack_mode = 0;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'h60 + 4 * i, 32'hC000_0000 + i);
        chk("rst_mid_req_before", mem_req_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_req", mem_req_o, 0);
        chk("rst_mid_empty", wbuf_empty_o, 1);
        wq.delete();
        arch = memv;
        @(negedge clk);
        rst = 1'b1;
        ack_mode = 1;
        base = wr_count;
        repeat (5) tick();
        chk("rst_mid_no_writes", wr_count - base, 0);
        chk("rst_mid_empty_after", wbuf_empty_o, 1);

        // Stray ack while idle.
        base = wr_count;
        repeat (3) tick();
        chk("stray_req", mem_req_o, 0);
        chk("stray_empty", wbuf_empty_o, 1);
        chk("stray_writes", wr_count - base, 0);

        // Random traffic.
        ack_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if (!core_ce_i) begin
                int r;
                r = $urandom_range(0, 9);
                if (r >= 3)
                    present((r < 6), 32'h100 + 4 * $urandom_range(0, 11) + $urandom_range(0, 3),
                            $urandom);
            end
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
